// File: rtl/router_fsm.sv
// router_fsm: control FSM of the 1x3 router; decodes header address, sequences header/payload/parity loads.
// Latency: Moore outputs decoded from the state register, valid in the cycle the state is entered.
// Backpressure: busy holds the source while waiting for an empty FIFO, while the FIFO is full, and around the header/parity.
// Optional feature: define ROUTER_FSM_ADDR3_DROP_EN to swallow address-3 packets in a DROP_PACKET state.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  // Four bits so that the drop state fits; every other code is illegal and recovers to decode.
  localparam logic [3:0] S_DECODE_ADDRESS     = 4'd0;
  localparam logic [3:0] S_WAIT_TILL_EMPTY    = 4'd1;
  localparam logic [3:0] S_LOAD_FIRST_DATA    = 4'd2;
  localparam logic [3:0] S_LOAD_DATA          = 4'd3;
  localparam logic [3:0] S_FIFO_FULL_STATE    = 4'd4;
  localparam logic [3:0] S_LOAD_AFTER_FULL    = 4'd5;
  localparam logic [3:0] S_LOAD_PARITY        = 4'd6;
  localparam logic [3:0] S_CHECK_PARITY_ERROR = 4'd7;
`ifdef ROUTER_FSM_ADDR3_DROP_EN
  localparam logic [3:0] S_DROP_PACKET        = 4'd8;
`endif

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [1:0] r_addr;
  logic       w_hdr_empty;
  logic       w_sel_empty;
  logic       w_sel_soft_rst;
  logic       w_soft_rst;
  logic       w_addr_load;

  // Empty flag of the FIFO addressed by the incoming header byte.
  always_comb begin
    w_hdr_empty = 1'b0;
    case (data_in)
      2'd0:    w_hdr_empty = fifo_empty_0;
      2'd1:    w_hdr_empty = fifo_empty_1;
      2'd2:    w_hdr_empty = fifo_empty_2;
      default: w_hdr_empty = 1'b0;
    endcase
  end

  // Empty flag and soft reset of the FIFO latched for the packet in flight.
  always_comb begin
    w_sel_empty    = 1'b0;
    w_sel_soft_rst = 1'b0;
    case (r_addr)
      2'd0: begin
        w_sel_empty    = fifo_empty_0;
        w_sel_soft_rst = soft_reset_0;
      end
      2'd1: begin
        w_sel_empty    = fifo_empty_1;
        w_sel_soft_rst = soft_reset_1;
      end
      2'd2: begin
        w_sel_empty    = fifo_empty_2;
        w_sel_soft_rst = soft_reset_2;
      end
      default: begin
        w_sel_empty    = 1'b0;
        w_sel_soft_rst = 1'b0;
      end
    endcase
  end

  // A soft reset only matters once a packet is in progress; decode ignores it.
  assign w_soft_rst  = (r_state != S_DECODE_ADDRESS) && w_sel_soft_rst;
  assign w_addr_load = (r_state == S_DECODE_ADDRESS) && pkt_valid && (data_in != 2'd3);

  // State and latched destination address.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_DECODE_ADDRESS;
      r_addr  <= 2'd0;
    end else begin
      r_state <= w_next_state;
      if (w_addr_load) begin
        r_addr <= data_in;
      end
    end
  end

  // Next-state decode; soft reset overrides every normal transition.
  always_comb begin
    w_next_state = S_DECODE_ADDRESS;
    if (w_soft_rst) begin
      w_next_state = S_DECODE_ADDRESS;
    end else begin
      case (r_state)
        S_DECODE_ADDRESS: begin
          if (pkt_valid && (data_in != 2'd3)) begin
            w_next_state = w_hdr_empty ? S_LOAD_FIRST_DATA : S_WAIT_TILL_EMPTY;
`ifdef ROUTER_FSM_ADDR3_DROP_EN
          end else if (pkt_valid) begin
            w_next_state = S_DROP_PACKET;
`endif
          end else begin
            w_next_state = S_DECODE_ADDRESS;
          end
        end
        S_WAIT_TILL_EMPTY:
          w_next_state = w_sel_empty ? S_LOAD_FIRST_DATA : S_WAIT_TILL_EMPTY;
        S_LOAD_FIRST_DATA:
          w_next_state = S_LOAD_DATA;
        S_LOAD_DATA: begin
          if (fifo_full)       w_next_state = S_FIFO_FULL_STATE;
          else if (!pkt_valid) w_next_state = S_LOAD_PARITY;
          else                 w_next_state = S_LOAD_DATA;
        end
        S_FIFO_FULL_STATE:
          w_next_state = fifo_full ? S_FIFO_FULL_STATE : S_LOAD_AFTER_FULL;
        S_LOAD_AFTER_FULL: begin
          if (parity_done)        w_next_state = S_DECODE_ADDRESS;
          else if (low_pkt_valid) w_next_state = S_LOAD_PARITY;
          else                    w_next_state = S_LOAD_DATA;
        end
        S_LOAD_PARITY:
          w_next_state = S_CHECK_PARITY_ERROR;
        S_CHECK_PARITY_ERROR:
          w_next_state = fifo_full ? S_FIFO_FULL_STATE : S_DECODE_ADDRESS;
`ifdef ROUTER_FSM_ADDR3_DROP_EN
        // Leave once the low pkt_valid of the parity byte has been seen.
        S_DROP_PACKET:
          w_next_state = pkt_valid ? S_DROP_PACKET : S_DECODE_ADDRESS;
`endif
        default:
          w_next_state = S_DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode straight from the state register.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b1;
    case (r_state)
      S_DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      S_WAIT_TILL_EMPTY: begin
        busy = 1'b1;
      end
      S_LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
      end
      S_LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      S_FIFO_FULL_STATE: begin
        full_state = 1'b1;
      end
      S_LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      S_LOAD_PARITY: begin
        write_enb_reg = 1'b1;
      end
      S_CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
      end
`ifdef ROUTER_FSM_ADDR3_DROP_EN
      S_DROP_PACKET: begin
        busy = 1'b0;
      end
`endif
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed stimulus for router_fsm, checked each cycle against a packet-level model.
// Latency: outputs compared on the falling edge, literal checks 1 time unit after the rising edge.
// Backpressure: fifo_full / fifo_empty / low_pkt_valid driven directly by the stimulus.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  always #5 clock = ~clock;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  // Output bundle order: detect_add, lfd, ld, laf, full, write_enb, rst_int, busy.
  wire [7:0] dut_vec = {detect_add, lfd_state, ld_state, laf_state, full_state,
                        write_enb_reg, rst_int_reg, busy};

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  int cnt_ld = 0, cnt_lfd = 0, cnt_wte = 0, cnt_ffs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Packet-phase model: what the router is doing with the current packet.
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_HEADER = 2, PH_PAYLOAD = 3,
                 PH_STALLED = 4, PH_RESUME = 5, PH_PARITY = 6, PH_CHECK = 7, PH_DROP = 8;
  int         m_ph = PH_IDLE;
  logic [1:0] m_addr = 2'd0;
  wire  [2:0] emp_v = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  wire  [2:0] sr_v  = {soft_reset_2, soft_reset_1, soft_reset_0};

  function automatic logic [7:0] ph_out(input int ph);
    case (ph)
      PH_IDLE:    return 8'b1000_0000;
      PH_WAIT:    return 8'b0000_0001;
      PH_HEADER:  return 8'b0100_0001;
      PH_PAYLOAD: return 8'b0010_0100;
      PH_STALLED: return 8'b0000_1001;
      PH_RESUME:  return 8'b0001_0101;
      PH_PARITY:  return 8'b0000_0101;
      PH_CHECK:   return 8'b0000_0011;
      PH_DROP:    return 8'b0000_0000;
      default:    return 8'hxx;
    endcase
  endfunction

  always @(posedge clock) begin
    if (!resetn) begin
      m_ph   <= PH_IDLE;
      m_addr <= 2'd0;
    end else if (m_ph != PH_IDLE && sr_v[m_addr]) begin
      m_ph <= PH_IDLE;
    end else begin
      case (m_ph)
        PH_IDLE: begin
          if (pkt_valid && data_in != 2'd3) begin
            m_addr <= data_in;
            m_ph   <= emp_v[data_in] ? PH_HEADER : PH_WAIT;
          end
`ifdef ROUTER_FSM_ADDR3_DROP_EN
          else if (pkt_valid) m_ph <= PH_DROP;
`endif
        end
        PH_WAIT:    if (emp_v[m_addr]) m_ph <= PH_HEADER;
        PH_HEADER:  m_ph <= PH_PAYLOAD;
        PH_PAYLOAD: m_ph <= fifo_full ? PH_STALLED : (!pkt_valid ? PH_PARITY : PH_PAYLOAD);
        PH_STALLED: if (!fifo_full) m_ph <= PH_RESUME;
        PH_RESUME:  m_ph <= parity_done ? PH_IDLE : (low_pkt_valid ? PH_PARITY : PH_PAYLOAD);
        PH_PARITY:  m_ph <= PH_CHECK;
        PH_CHECK:   m_ph <= fifo_full ? PH_STALLED : PH_IDLE;
        PH_DROP:    if (!pkt_valid) m_ph <= PH_IDLE;
        default:    m_ph <= PH_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model, plus occupancy counters for literal checks.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("cycle_outputs", {24'd0, dut_vec}, {24'd0, ph_out(m_ph)});
      if (ld_state)   cnt_ld++;
      if (lfd_state)  cnt_lfd++;
      if (full_state) cnt_ffs++;
      if (dut_vec == 8'b0000_0001) cnt_wte++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clr_cnt();
    cnt_ld = 0; cnt_lfd = 0; cnt_wte = 0; cnt_ffs = 0;
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;

    // Reset
    step(1);
    chk_en = 1'b1;
    step(1);
    resetn = 1'b1;
    chk("reset_outputs", {24'd0, dut_vec}, 32'h80);
    step(1);
    chk("idle_after_reset", {24'd0, dut_vec}, 32'h80);

    // Header 0x39: addr 1, 14 payload bytes
    clr_cnt();
    pkt_valid = 1'b1; data_in = 2'd1;
    step(1);
    chk("hdr_lfd", {24'd0, dut_vec}, 32'h41);
    step(14);
    pkt_valid = 1'b0; data_in = 2'd0;
    step(1);
    chk("parity_load", {24'd0, dut_vec}, 32'h05);
    step(2);
    chk("pkt1_back_to_da", {24'd0, dut_vec}, 32'h80);
    chk("pkt1_ld_cycles", cnt_ld, 32'd14);
    chk("pkt1_lfd_cycles", cnt_lfd, 32'd1);

    // Addr 2 with a non-empty FIFO for 5 cycles
    clr_cnt();
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
    step(5);
    fifo_empty_2 = 1'b1;
    step(1);
    chk("wte_to_lfd", {24'd0, dut_vec}, 32'h41);
    chk("wte_cycles", cnt_wte, 32'd5);
    step(3);
    pkt_valid = 1'b0;
    step(3);
    chk("pkt2_back_to_da", {24'd0, dut_vec}, 32'h80);

    // Full stall mid-payload on addr 0
    clr_cnt();
    pkt_valid = 1'b1; data_in = 2'd0;
    step(3);
    fifo_full = 1'b1;
    step(3);
    fifo_full = 1'b0;
    step(1);
    chk("laf_after_full", {24'd0, dut_vec}, 32'h15);
    step(1);
    chk("ld_after_laf", {24'd0, dut_vec}, 32'h24);
    chk("ffs_cycles", cnt_ffs, 32'd3);
    fifo_full = 1'b1;
    step(1);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    step(2);
    chk("laf_low_to_lp", {24'd0, dut_vec}, 32'h05);
    low_pkt_valid = 1'b0; pkt_valid = 1'b0;
    step(1);
    chk("cpe_entered", {24'd0, dut_vec}, 32'h03);
    fifo_full = 1'b1;
    step(1);
    chk("cpe_full_to_ffs", {24'd0, dut_vec}, 32'h09);
    fifo_full = 1'b0;
    step(1);
    parity_done = 1'b1;
    step(1);
    parity_done = 1'b0;
    chk("laf_parity_done_to_da", {24'd0, dut_vec}, 32'h80);

    // Soft resets during payload on addr 0
    pkt_valid = 1'b1; data_in = 2'd0;
    step(2);
    soft_reset_1 = 1'b1;
    step(1);
    soft_reset_1 = 1'b0;
    chk("soft_reset_other_ignored", {24'd0, dut_vec}, 32'h24);
    soft_reset_0 = 1'b1; pkt_valid = 1'b0;
    step(1);
    soft_reset_0 = 1'b0;
    chk("soft_reset_sel_to_da", {24'd0, dut_vec}, 32'h80);

    // Address 3 header
    pkt_valid = 1'b1; data_in = 2'd3;
    step(3);
`ifdef ROUTER_FSM_ADDR3_DROP_EN
    chk("addr3_drop", {24'd0, dut_vec}, 32'h00);
`else
    chk("addr3_ignored", {24'd0, dut_vec}, 32'h80);
`endif
    pkt_valid = 1'b0; data_in = 2'd0;
    step(1);
    chk("addr3_back_to_da", {24'd0, dut_vec}, 32'h80);
    step(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control FSM of the 1x3 router. Sits directly upstream of the three per-destination FIFOs.
- Decodes the 2-bit address in each header byte and sequences header, payload and parity loading.
- Drives lfd_state to the FIFOs, and write/control strobes to the input register stage.
- Stalls the source via busy when the target FIFO is occupied or full.

Parameters:
- None. Three destinations, 2-bit address (data_in[1:0]), and state encoding are fixed.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- pkt_valid  input  1  source asserts for the header and payload bytes; deasserts for the parity byte.
- data_in  input  2  address field of the current input byte (header bits [1:0]).
- fifo_full  input  1  full flag of the currently selected FIFO.
- fifo_empty_0, fifo_empty_1, fifo_empty_2  input  1 each  empty flags of FIFO 0/1/2.
- soft_reset_0, soft_reset_1, soft_reset_2  input  1 each  per-FIFO read timeout soft resets.
- parity_done  input  1  input register stage has latched the parity byte.
- low_pkt_valid  input  1  pkt_valid fell while the FSM was in FIFO_FULL_STATE.
- detect_add  output  1  FSM in DECODE_ADDRESS.
- lfd_state  output  1  FSM in LOAD_FIRST_DATA; header byte is being written.
- ld_state  output  1  FSM in LOAD_DATA.
- laf_state  output  1  FSM in LOAD_AFTER_FULL.
- full_state  output  1  FSM in FIFO_FULL_STATE.
- write_enb_reg  output  1  FIFO write enable request.
- rst_int_reg  output  1  FSM in CHECK_PARITY_ERROR; clears the internal parity register.
- busy  output  1  source must hold the current byte.

Behaviour:
- Reset and clocking: single clock domain; reset is synchronous, active-low (resetn sampled on the rising edge of clock).
- resetn=0 -> state DECODE_ADDRESS, addr_q=0.
- Outputs after reset: detect_add=1; all other outputs 0.
- Outputs are Moore decodes of the state register, valid the same cycle the state is entered. No output registers.
- addr_q latches data_in when state==DECODE_ADDRESS && pkt_valid && data_in!=3.
- Soft reset: when state!=DECODE_ADDRESS and soft_reset_<addr_q>=1, next state is DECODE_ADDRESS.
  - Priority: resetn, then soft reset, then normal transitions.
  - Soft resets of non-selected FIFOs are ignored.
- Per-state behaviour (outputs not listed are 0; busy=1 unless stated):
  - DECODE_ADDRESS: detect_add=1, busy=0.
    - pkt_valid && data_in<3 && fifo_empty_<data_in> -> LOAD_FIRST_DATA.
    - pkt_valid && data_in<3 && !fifo_empty_<data_in> -> WAIT_TILL_EMPTY.
    - Otherwise stay.
  - WAIT_TILL_EMPTY: write_enb_reg=0. fifo_empty_<addr_q> -> LOAD_FIRST_DATA; else stay.
  - LOAD_FIRST_DATA: lfd_state=1. Unconditionally -> LOAD_DATA (exactly one cycle).
  - LOAD_DATA: ld_state=1, write_enb_reg=1, busy=0.
    - fifo_full -> FIFO_FULL_STATE (takes priority over !pkt_valid).
    - else !pkt_valid -> LOAD_PARITY.
    - else stay.
  - FIFO_FULL_STATE: full_state=1, write_enb_reg=0. !fifo_full -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL: laf_state=1, write_enb_reg=1.
    - parity_done -> DECODE_ADDRESS.
    - else low_pkt_valid -> LOAD_PARITY.
    - else -> LOAD_DATA.
  - LOAD_PARITY: write_enb_reg=1. Unconditionally -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: rst_int_reg=1. fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- Address 3 handling: header with data_in==3 is not accepted; FSM stays in DECODE_ADDRESS (see optional feature).
- Minimum packet cost: header to return to DECODE_ADDRESS with a 1-byte payload and no stalls is 5 cycles: DA, LFD, LD, LP, CPE.
- Unused or illegal state encodings -> DECODE_ADDRESS on the next edge.

Optional Feature:
- Macro: ROUTER_FSM_ADDR3_DROP_EN.
- Defined: adds state DROP_PACKET.
  - DECODE_ADDRESS with pkt_valid && data_in==3 -> DROP_PACKET.
  - DROP_PACKET: busy=0, write_enb_reg=0. Exits to DECODE_ADDRESS on the cycle after pkt_valid is first seen low (parity byte consumed).
- Undefined: address 3 headers are ignored in DECODE_ADDRESS, and the state is never generated.

Test Plan:
1. Reset: hold resetn=0 for 2 cycles, then release -> detect_add=1, busy=0, all other outputs 0.
2. Header 0x39 (len 14, addr 1), fifo_empty_1=1, pkt_valid high for 15 cycles -> state sequence DA, LFD (1 cycle, lfd_state=1), LD for 14 cycles (write_enb_reg=1), then LP and CPE, then DA. busy=0 during LD.
3. Header addr 2 with fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY for 5 cycles with busy=1 and write_enb_reg=0. LFD one cycle after fifo_empty_2 rises.
4. fifo_full=1 for 3 cycles mid-payload -> FIFO_FULL_STATE for 3 cycles (full_state=1, busy=1), then LOAD_AFTER_FULL, then LD. Repeat with low_pkt_valid=1 -> LAF then LP.
5. In LD on addr 0, pulse soft_reset_0 -> DA on the next edge. A soft_reset_1 pulse in the same scenario has no effect.
6. Header data_in=3 -> without the macro, stays in DA. With ROUTER_FSM_ADDR3_DROP_EN, enters DROP_PACKET and returns to DA after pkt_valid falls, with write_enb_reg=0 throughout.
